// File: rtl/tdm_voice_phase_generator.sv
// Four-voice TDM oscillator: one voice slot per dsp_clk, registered outputs
// for the downstream sample pipeline (chan / enable / fix15 sample).
module tdm_voice_phase_generator #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned CHANBITS   = 2,
    parameter int unsigned PH_W       = 24,
    parameter int unsigned D_W        = 16
) (
    input  logic                dsp_clk,
    input  logic                dsp_rst,
    input  logic                sample_tick,
    input  logic                cfg_wr,
    input  logic [CHANBITS-1:0] cfg_voice,
    input  logic [PH_W-1:0]     cfg_incr,
    input  logic [1:0]          cfg_wave,
    input  logic                gate_set,
    input  logic                gate_clr,
    input  logic [CHANBITS-1:0] gate_voice,
    output logic [CHANBITS-1:0] chan_out,
    output logic                chan_en_out,
    output logic [D_W-1:0]      data_out,
    output logic                frame_start
);
    localparam int unsigned W15 = D_W - 1;

    logic [CHANBITS-1:0] slot_q, slot_d;
    logic [PH_W-1:0]     phase_q [NUM_VOICES];
    logic [PH_W-1:0]     phase_d [NUM_VOICES];
    logic [PH_W-1:0]     incr_q  [NUM_VOICES];
    logic [PH_W-1:0]     incr_d  [NUM_VOICES];
    logic [1:0]          wave_q  [NUM_VOICES];
    logic [1:0]          wave_d  [NUM_VOICES];
    logic [NUM_VOICES-1:0] gate_q, gate_d;
    logic                tick_pend_q, tick_pend_d;
    logic                frame_adv_q, frame_adv_d;

    logic [PH_W-1:0] cur_phase;
    logic [1:0]      cur_wave;
    logic            cur_gate;
    logic [W15-1:0]  saw, tri_t, wave15;
    logic [D_W-1:0]  data_d;

    // Waveform of the voice owning this slot, from its pre-update phase.
    always_comb begin
        cur_phase = phase_q[slot_q];
        cur_wave  = wave_q[slot_q];
        cur_gate  = gate_q[slot_q];
        saw       = cur_phase[PH_W-1 -: W15];
        tri_t     = cur_phase[PH_W-2 -: W15];
        case (cur_wave)
            2'd0:    wave15 = saw;
            2'd1:    wave15 = {W15{cur_phase[PH_W-1]}};
            2'd2:    wave15 = cur_phase[PH_W-1] ? ~tri_t : tri_t;
            default: wave15 = ~saw;
        endcase
        data_d = cur_gate ? {{(D_W - W15){1'b0}}, wave15} : '0;
    end

    always_comb begin
        slot_d = (slot_q == CHANBITS'(NUM_VOICES - 1)) ? '0 : slot_q + 1'b1;

        phase_d = phase_q;
        if (frame_adv_q && cur_gate) begin
            phase_d[slot_q] = cur_phase + incr_q[slot_q];
        end
        // Hard sync takes priority over the advance, even when clr wins the gate.
        if (gate_set) begin
            phase_d[gate_voice] = '0;
        end

        gate_d = gate_q;
        if (gate_set) gate_d[gate_voice] = 1'b1;
        if (gate_clr) gate_d[gate_voice] = 1'b0;

        incr_d = incr_q;
        wave_d = wave_q;
        if (cfg_wr) begin
            incr_d[cfg_voice] = cfg_incr;
            wave_d[cfg_voice] = cfg_wave;
        end

        // A tick landing in the slot-0 cycle is carried into the next frame.
        frame_adv_d = frame_adv_q;
        if (slot_q == '0) begin
            frame_adv_d = tick_pend_q;
            tick_pend_d = sample_tick;
        end else begin
            tick_pend_d = tick_pend_q | sample_tick;
        end
    end

    always_ff @(posedge dsp_clk) begin
        if (dsp_rst) begin
            slot_q      <= '0;
            gate_q      <= '0;
            tick_pend_q <= 1'b0;
            frame_adv_q <= 1'b0;
            for (int i = 0; i < int'(NUM_VOICES); i++) begin
                phase_q[i] <= '0;
                incr_q[i]  <= '0;
                wave_q[i]  <= '0;
            end
            chan_out    <= '0;
            chan_en_out <= 1'b0;
            data_out    <= '0;
            frame_start <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            gate_q      <= gate_d;
            tick_pend_q <= tick_pend_d;
            frame_adv_q <= frame_adv_d;
            phase_q     <= phase_d;
            incr_q      <= incr_d;
            wave_q      <= wave_d;
            chan_out    <= slot_q;
            chan_en_out <= cur_gate;
            data_out    <= data_d;
            frame_start <= (slot_q == '0);
        end
    end

endmodule

// File: tb/tb_tdm_voice_phase_generator.sv
// Bench for tdm_voice_phase_generator: per-cycle compare against a behavioural
// model, directed literal scenarios, then randomized traffic.
module tb_tdm_voice_phase_generator;
    logic        dsp_clk = 1'b0;
    logic        dsp_rst;
    logic        sample_tick;
    logic        cfg_wr;
    logic [1:0]  cfg_voice;
    logic [23:0] cfg_incr;
    logic [1:0]  cfg_wave;
    logic        gate_set;
    logic        gate_clr;
    logic [1:0]  gate_voice;
    logic [1:0]  chan_out;
    logic        chan_en_out;
    logic [15:0] data_out;
    logic        frame_start;

    int checks = 0;
    int failures = 0;

    tdm_voice_phase_generator dut (
        .dsp_clk     (dsp_clk),
        .dsp_rst     (dsp_rst),
        .sample_tick (sample_tick),
        .cfg_wr      (cfg_wr),
        .cfg_voice   (cfg_voice),
        .cfg_incr    (cfg_incr),
        .cfg_wave    (cfg_wave),
        .gate_set    (gate_set),
        .gate_clr    (gate_clr),
        .gate_voice  (gate_voice),
        .chan_out    (chan_out),
        .chan_en_out (chan_en_out),
        .data_out    (data_out),
        .frame_start (frame_start)
    );

    always #5 dsp_clk = ~dsp_clk;

    // Behavioural model state
    int unsigned m_phase [4];
    int unsigned m_incr  [4];
    int unsigned m_wave  [4];
    bit          m_gate  [4];
    int unsigned m_slot;
    bit          m_pend, m_adv, m_valid = 1'b0;
    logic [1:0]  e_chan;
    logic        e_en, e_fs;
    logic [15:0] e_data;

    function automatic int unsigned wave_of(input int unsigned ph, input int unsigned w);
        int unsigned p, t;
        bit hi;
        p  = ph / 512;
        t  = (ph / 256) % 32768;
        hi = (ph >= 32'h800000);
        case (w)
            0:       return p;
            1:       return hi ? 32'h7FFF : 32'h0;
            2:       return hi ? (32'h7FFF - t) : t;
            default: return 32'h7FFF - p;
        endcase
    endfunction

    task automatic model_step();
        if (dsp_rst) begin
            for (int i = 0; i < 4; i++) begin
                m_phase[i] = 0; m_incr[i] = 0; m_wave[i] = 0; m_gate[i] = 0;
            end
            m_slot = 0; m_pend = 0; m_adv = 0;
            e_chan = 0; e_en = 0; e_data = 0; e_fs = 0;
            m_valid = 1'b1;
        end else begin
            int unsigned s;
            int unsigned gv;
            s = m_slot;
            e_chan = 2'(s);
            e_en   = m_gate[s];
            e_data = m_gate[s] ? 16'(wave_of(m_phase[s], m_wave[s])) : 16'h0;
            e_fs   = (s == 0);
            if (m_adv && m_gate[s]) m_phase[s] = (m_phase[s] + m_incr[s]) % 32'h1000000;
            gv = int'(gate_voice);
            if (gate_set) begin
                m_phase[gv] = 0;
                m_gate[gv]  = 1;
            end
            if (gate_clr) m_gate[gv] = 0;
            if (cfg_wr) begin
                m_incr[int'(cfg_voice)] = int'(cfg_incr);
                m_wave[int'(cfg_voice)] = int'(cfg_wave);
            end
            if (s == 0) begin
                m_adv  = m_pend;
                m_pend = sample_tick;
            end else begin
                m_pend = m_pend || sample_tick;
            end
            m_slot = (s + 1) % 4;
        end
    endtask

    initial forever begin
        @(posedge dsp_clk);
        model_step();
    end

    initial forever begin
        @(negedge dsp_clk);
        if (m_valid) begin
            checks++;
            if ({chan_out, chan_en_out, data_out, frame_start} !== {e_chan, e_en, e_data, e_fs}) begin
                failures++;
                $display("FAIL cycle_cmp t=%0t actual chan=%h en=%b data=%h fs=%b required chan=%h en=%b data=%h fs=%b",
                         $time, chan_out, chan_en_out, data_out, frame_start, e_chan, e_en, e_data, e_fs);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle();
        sample_tick = 0; cfg_wr = 0; cfg_voice = 0; cfg_incr = 0; cfg_wave = 0;
        gate_set = 0; gate_clr = 0; gate_voice = 0; dsp_rst = 0;
    endtask

    // Advance to the next negedge whose output slot is c, bounded.
    task automatic wait_chan(input int c);
        for (int n = 0; n < 8; n++) begin
            @(negedge dsp_clk);
            if (int'(chan_out) == c) return;
        end
        checks++;
        failures++;
        $display("FAIL wait_chan timeout actual=%0d required=%0d", chan_out, c);
    endtask

    task automatic drain();
        repeat (12) @(negedge dsp_clk);
    endtask

    int unsigned tri_tab [8] = '{32'h0, 32'h2000, 32'h4000, 32'h6000,
                                 32'h7FFF, 32'h5FFF, 32'h3FFF, 32'h1FFF};

    initial begin
        int unsigned j, k0;
        idle();
        dsp_rst = 1;
        repeat (3) @(negedge dsp_clk);
        dsp_rst = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge dsp_clk);
            check("reset_chan", 32'(chan_out), 32'(i % 4));
            check("reset_en", 32'(chan_en_out), 0);
            check("reset_data", 32'(data_out), 0);
            check("reset_fs", 32'(frame_start), 32'(i % 4 == 0));
        end

        cfg_wr = 1; cfg_voice = 0; cfg_incr = 24'h010000; cfg_wave = 0;
        gate_set = 1; gate_voice = 0;
        @(negedge dsp_clk);
        cfg_voice = 1; cfg_incr = 24'h400000; cfg_wave = 1; gate_voice = 1;
        @(negedge dsp_clk);
        cfg_voice = 2; cfg_incr = 24'h200000; cfg_wave = 2; gate_voice = 2;
        @(negedge dsp_clk);
        idle();

        // One tick per frame, issued in slot 2.
        for (int k = 0; k < 260; k++) begin
            wait_chan(0);
            k0 = (k >= 2) ? 32'(k - 2) : 0;
            check("v0_saw", 32'(data_out), (k0 * 32'h80) % 32'h8000);
            check("v0_en", 32'(chan_en_out), 1);
            @(negedge dsp_clk);
            j = (k >= 1) ? 32'(k - 1) : 0;
            check("v1_square", 32'(data_out), (j % 4 >= 2) ? 32'h7FFF : 32'h0);
            sample_tick = 1;
            @(negedge dsp_clk);
            check("v2_tri", 32'(data_out), tri_tab[j % 8]);
            sample_tick = 0;
        end
        drain();
        wait_chan(0);
        check("v0_after_260", 32'(data_out), 32'h200);

        // Three ticks in one frame collapse into one advance.
        sample_tick = 1;
        repeat (3) @(negedge dsp_clk);
        sample_tick = 0;
        drain();
        wait_chan(0);
        check("v0_multi_tick", 32'(data_out), 32'h280);

        // Tick during the slot-0 cycle.
        wait_chan(3);
        sample_tick = 1;
        @(negedge dsp_clk);
        sample_tick = 0;
        drain();
        wait_chan(0);
        check("v0_slot0_tick", 32'(data_out), 32'h300);

        // Hard sync on a running voice.
        wait_chan(1);
        gate_set = 1; gate_voice = 0;
        @(negedge dsp_clk);
        gate_set = 0;
        wait_chan(0);
        check("v0_resync_data", 32'(data_out), 0);
        check("v0_resync_en", 32'(chan_en_out), 1);

        // Run V3, then set+clr together.
        cfg_wr = 1; cfg_voice = 3; cfg_incr = 24'h123456; cfg_wave = 0;
        gate_set = 1; gate_voice = 3;
        @(negedge dsp_clk);
        idle();
        for (int f = 0; f < 3; f++) begin
            wait_chan(1);
            sample_tick = 1;
            @(negedge dsp_clk);
            sample_tick = 0;
        end
        wait_chan(3);
        check("v3_running_en", 32'(chan_en_out), 1);
        wait_chan(0);
        gate_set = 1; gate_clr = 1; gate_voice = 3;
        @(negedge dsp_clk);
        idle();
        wait_chan(3);
        check("v3_setclr_en", 32'(chan_en_out), 0);
        check("v3_setclr_data", 32'(data_out), 0);

        // Reset asserted for the slot-2 edge.
        wait_chan(1);
        dsp_rst = 1;
        @(negedge dsp_clk);
        check("midrst_chan", 32'(chan_out), 0);
        check("midrst_data", 32'(data_out), 0);
        check("midrst_fs", 32'(frame_start), 0);
        dsp_rst = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge dsp_clk);
            check("midrst_seq", 32'(chan_out), 32'(i % 4));
            check("midrst_en", 32'(chan_en_out), 0);
        end

        for (int c = 0; c < 4000; c++) begin
            sample_tick = ($urandom % 3) == 0;
            cfg_wr      = ($urandom % 8) == 0;
            cfg_voice   = 2'($urandom);
            cfg_incr    = 24'($urandom);
            cfg_wave    = 2'($urandom);
            gate_set    = ($urandom % 10) == 0;
            gate_clr    = ($urandom % 14) == 0;
            gate_voice  = 2'($urandom);
            dsp_rst     = ($urandom % 400) == 0;
            @(negedge dsp_clk);
        end
        idle();
        repeat (4) @(negedge dsp_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
